// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl - pipeline hazard controller for the 5-stage pipeline.
//
// Produces registered 2-bit operand forwarding selects for the EX stage
// (00 = register file, 01 = EX/MEM result, 10 = MEM/WB result), sequences
// one-cycle load-use stalls and multi-cycle MUL/DIV occupancy of EX, and
// drives the PC / IF/ID / ID/EX stall and flush controls.
//
// Parameters:
//   MUL_LAT  MUL occupancy of EX in cycles (>= 1)
//   DIV_LAT  DIV occupancy of EX in cycles (>= 1, <= 255)
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_rs/id_rt, id_use_*    source registers of the ID instruction
//   ex_rd, ex_regwrite,
//   ex_memread               destination / kind of the EX instruction
//   mem_rd, mem_regwrite     destination of the MEM instruction
//   ex_mdu_start, ex_mdu_div MUL/DIV on its first EX cycle, 1 = DIV
//   id_branch_taken          branch/jump resolved taken in ID
//   fwd_a_sel, fwd_b_sel     registered forwarding selects for EX
//   pc_stall, ifid_stall,
//   idex_stall               hold controls
//   idex_flush, ifid_flush   bubble into ID/EX, squash IF/ID
//   mdu_busy                 MUL/DIV occupying EX
//   stall_cycles             count of pc_stall cycles
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, stall_cycles is a saturating counter;
//                       otherwise it is tied to 0.

module hazard_fwd_ctrl #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [4:0]  mem_rd,
   input  logic        mem_regwrite,
   input  logic        ex_mdu_start,
   input  logic        ex_mdu_div,
   input  logic        id_branch_taken,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idex_stall,
   output logic        idex_flush,
   output logic        ifid_flush,
   output logic        mdu_busy,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {StRun, StLoadStall, StMduWait} state_e;

   localparam logic [7:0] MulLoad = 8'(MUL_LAT - 1);
   localparam logic [7:0] DivLoad = 8'(DIV_LAT - 1);

   state_e     state_q, state_d;
   logic [7:0] mdu_cnt_q, mdu_cnt_d;
   logic [7:0] mdu_load;
   logic       load_use_raw;
   logic       load_use;
   logic [1:0] fwd_a_d, fwd_b_d;

   // Forwarding decision for one operand; the EX match wins over MEM and
   // r0 is never forwarded. A load in EX has no result yet, so it is skipped.
   function automatic logic [1:0] fwd_decide(
      input logic       use_r,
      input logic [4:0] r,
      input logic [4:0] e_rd,
      input logic       e_wr,
      input logic       e_ld,
      input logic [4:0] m_rd,
      input logic       m_wr
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_r && (r != 5'd0)) begin
         if (e_wr && !e_ld && (e_rd == r)) begin
            sel = 2'b01;
         end else if (m_wr && (m_rd == r)) begin
            sel = 2'b10;
         end
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_d = fwd_decide(id_use_rs, id_rs, ex_rd, ex_regwrite, ex_memread,
                           mem_rd, mem_regwrite);
      fwd_b_d = fwd_decide(id_use_rt, id_rt, ex_rd, ex_regwrite, ex_memread,
                           mem_rd, mem_regwrite);
   end

   // Load-use detection. Suppressed while the MDU freezes EX; gated by rst
   // so every output reads 0 while reset is held.
   always_comb begin
      load_use_raw = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                     ((id_use_rs && (ex_rd == id_rs)) ||
                      (id_use_rt && (ex_rd == id_rt)));
      load_use     = load_use_raw && (state_q != StMduWait) && !rst;
   end

   assign mdu_load = ex_mdu_div ? DivLoad : MulLoad;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StRun;
         mdu_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         mdu_cnt_q <= mdu_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      unique case (state_q)
         StRun: begin
            if (ex_mdu_start) begin
               mdu_cnt_d = mdu_load;
            end
            if (ex_mdu_start && (mdu_load != 8'd0)) begin
               state_d = StMduWait;
            end else if (load_use) begin
               state_d = StLoadStall;
            end
         end
         StLoadStall: begin
            state_d = StRun;
         end
         StMduWait: begin
            // ex_mdu_start is ignored here: the counter only runs down.
            mdu_cnt_d = mdu_cnt_q - 8'd1;
            if (mdu_cnt_q == 8'd1) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d   = StRun;
            mdu_cnt_d = 8'd0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      mdu_busy   = (mdu_cnt_q != 8'd0);
      pc_stall   = mdu_busy || load_use;
      ifid_stall = mdu_busy || load_use;
      idex_stall = mdu_busy;
      idex_flush = load_use;
      // A branch seen under a stall is simply re-evaluated once it releases.
      ifid_flush = id_branch_taken && !pc_stall && !rst;
   end

   // Forwarding select registers: hold under MDU stall, 00 for a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_sel <= 2'b00;
         fwd_b_sel <= 2'b00;
      end else if (idex_stall) begin
         fwd_a_sel <= fwd_a_sel;
         fwd_b_sel <= fwd_b_sel;
      end else if (load_use) begin
         fwd_a_sel <= 2'b00;
         fwd_b_sel <= 2'b00;
      end else begin
         fwd_a_sel <= fwd_a_d;
         fwd_b_sel <= fwd_b_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage dynamic pipeline.
- Generates the registered 2-bit select codes for the two 32-bit 3-to-1 ALU operand forwarding muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Sequences load-use stalls and multi-cycle MUL/DIV occupancy.
- Issues PC, IF/ID and ID/EX stall and flush controls.

Parameters:
MUL_LAT, 3, MUL occupancy in EX in cycles (>=1)
DIV_LAT, 32, DIV occupancy in EX in cycles (>=1, <=255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
id_rs  input  5  rs of instruction in ID
id_rt  input  5  rt of instruction in ID
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
ex_rd  input  5  destination register in EX
ex_regwrite  input  1  EX instruction writes a register
ex_memread  input  1  EX instruction is a load
mem_rd  input  5  destination register in MEM
mem_regwrite  input  1  MEM instruction writes a register
ex_mdu_start  input  1  EX holds a MUL/DIV on its first EX cycle
ex_mdu_div  input  1  1 = DIV, 0 = MUL; valid with ex_mdu_start
id_branch_taken  input  1  branch/jump resolved taken in ID
fwd_a_sel  output  2  operand A mux select for the EX instruction
fwd_b_sel  output  2  operand B mux select for the EX instruction
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID register
idex_stall  output  1  hold ID/EX register and fwd selects
idex_flush  output  1  load bubble into ID/EX
ifid_flush  output  1  squash IF/ID (taken branch)
mdu_busy  output  1  MUL/DIV occupying EX
stall_cycles  output  32  performance counter (see Optional Feature)

Behaviour:
- Reset (async, immediate): all outputs 0, FSM = RUN, MDU counter = 0. Reset mid-stall or mid-MDU aborts the stall or operation; first cycle after release is RUN.
- FSM states: RUN, LOAD_STALL, MDU_WAIT.
- Forwarding decision, made in ID and registered at the edge the ID instruction advances:
  - A side: if id_use_rs, id_rs != 0, ex_regwrite, !ex_memread and ex_rd == id_rs -> 01.
  - Else if id_use_rs, id_rs != 0, mem_regwrite and mem_rd == id_rs -> 10.
  - Else -> 00.
  - B side: identical logic using id_rt / id_use_rt.
  - EX match has priority over MEM match.
  - Register 0 is never forwarded.
- Load-use hazard: ex_memread, ex_regwrite, ex_rd != 0, and ex_rd matches a used id_rs or id_rt.
  - Asserts pc_stall, ifid_stall and idex_flush combinationally in that cycle.
  - Registered fwd selects load 00 for the bubble.
  - FSM RUN -> LOAD_STALL for exactly one cycle, then RUN.
  - On the retry cycle the load is in MEM, so the decision yields 10.
- MDU: in RUN, ex_mdu_start loads counter = (ex_mdu_div ? DIV_LAT : MUL_LAT) - 1.
  - Counter 0 -> stays RUN, no stall.
  - Counter > 0 -> MDU_WAIT. mdu_busy, pc_stall, ifid_stall and idex_stall are asserted while counter != 0 (registered, starting the cycle after start). Counter decrements each cycle.
  - When counter reaches 0: MDU_WAIT -> RUN and all stalls drop in the same cycle.
  - ex_mdu_start is ignored while in MDU_WAIT.
  - fwd selects hold while idex_stall is asserted.
- Priority: MDU_WAIT over load-use over branch.
  - ifid_flush = id_branch_taken & !pc_stall.
  - A branch seen during any stall is re-evaluated when the stall releases.
- Load-use detection is suppressed while MDU_WAIT is active, because the EX instruction is frozen.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
  - Defined: stall_cycles increments on every cycle with pc_stall = 1, saturates at 0xFFFFFFFF, and resets to 0.
  - Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- ID rs=5, EX rd=5 regwrite, not a load -> next cycle fwd_a_sel=01, fwd_b_sel=00, no stall.
- ID rs=rt=7, EX rd=7 and MEM rd=7 both regwrite -> fwd_a_sel=fwd_b_sel=01 (EX priority). Repeat with rd=0 -> both 00.
- EX lw rd=9, ID uses rt=9 -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle, bubble selects 00. Next cycle fwd_b_sel=10, stalls 0.
- DIV start with DIV_LAT=32 -> mdu_busy high exactly 31 cycles, then low. MUL with MUL_LAT=1 -> never busy. stall_cycles=31 after DIV when the macro is defined.
- id_branch_taken=1 during load-use stall -> ifid_flush=0. Next (unstalled) cycle with branch still taken -> ifid_flush=1.
- Assert rst during cycle 10 of DIV -> all outputs 0 asynchronously. After release, ID/EX match produces normal forwarding with no stall.
